// File: rtl/key_event_gen.sv
// key_event_gen: turns debounced key levels into press/auto-repeat events on a valid/ready port
module key_event_gen #(
  parameter int NKEYS = 4,
  parameter int KW = 2,
  parameter int TICK_DIV = 50000,
  parameter int NTBITS = 16,
  parameter int DELAY_MS = 250,
  parameter int REPEAT_MS = 80,
  parameter int MSBITS = 8,
  parameter logic [NKEYS-1:0] REPEAT_MASK = 4'b0111
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [NKEYS-1:0] KeyClean,
  output logic             EventValid,
  output logic [KW-1:0]    EventCode,
  input  logic             EventReady,
  output logic             Drop
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} state_t;
  localparam logic [MSBITS-1:0] DLY = MSBITS'(DELAY_MS - 1);
  localparam logic [MSBITS-1:0] RPT = MSBITS'(REPEAT_MS - 1);
  state_t state [NKEYS];
  state_t state_nx [NKEYS];
  logic [MSBITS-1:0] cnt [NKEYS];
  logic [MSBITS-1:0] cnt_nx [NKEYS];
  logic [NTBITS-1:0] pre;
  logic tick, load, drop_nx;
  logic [NKEYS-1:0] prev, pend, req, xfer, pend_nx;
  logic [KW-1:0] sel;
  assign tick = pre == NTBITS'(TICK_DIV - 1);
  // free-running millisecond prescaler
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  // per-key state, tick counter and previous level
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      prev <= '0;
      for (int k = 0; k < NKEYS; k++) begin
        state[k] <= IDLE;
        cnt[k] <= '0;
      end
    end else begin
      prev <= KeyClean;
      for (int k = 0; k < NKEYS; k++) begin
        state[k] <= state_nx[k];
        cnt[k] <= cnt_nx[k];
      end
    end
  // per-key next state: press request, then delayed and periodic repeats while held
  always_comb begin
    for (int k = 0; k < NKEYS; k++) begin
      state_nx[k] = state[k];
      cnt_nx[k] = cnt[k];
      req[k] = 1'b0;
      if (!KeyClean[k]) begin
        state_nx[k] = IDLE;
        cnt_nx[k] = '0;
      end else
        case (state[k])
          IDLE:
            if (!prev[k]) begin
              req[k] = 1'b1;
              cnt_nx[k] = '0;
              state_nx[k] = REPEAT_MASK[k] ? DELAY : HELD;
            end
          DELAY, REPEAT:
            if (tick) begin
              if (cnt[k] == (state[k] == DELAY ? DLY : RPT)) begin
                req[k] = 1'b1;
                cnt_nx[k] = '0;
                state_nx[k] = REPEAT;
              end else cnt_nx[k] = cnt[k] + 1'b1;
            end
          default: ;
        endcase
    end
  end
  // lowest-index pending key wins the free output slot
  always_comb begin
    sel = '0;
    for (int k = NKEYS - 1; k >= 0; k--)
      if (pend[k]) sel = KW'(k);
    load = !EventValid && |pend;
    xfer = load ? (NKEYS'(1) << sel) : '0;
    pend_nx = (pend & ~xfer) | req;
    drop_nx = |(req & pend & ~xfer);
  end
  // pending bits, drop pulse and the single-entry output slot
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      pend <= '0;
      Drop <= 1'b0;
      EventValid <= 1'b0;
      EventCode <= '0;
    end else begin
      pend <= pend_nx;
      Drop <= drop_nx;
      if (EventValid) EventValid <= !EventReady;
      else if (load) begin
        EventValid <= 1'b1;
        EventCode <= sel;
      end
    end
endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: scoreboard bench for key_event_gen with millisecond ticks shrunk to 4 cycles
module tb_key_event_gen;
  localparam int TD = 4;
  localparam int DL = 3;
  localparam int RP = 2;
  localparam logic [3:0] MASK = 4'b0111;
  logic clk = 0, rst_n = 0, ready = 1;
  logic [3:0] keys = '0;
  logic valid, drop;
  logic [1:0] code;
  typedef struct {int code; int t;} ev_s;
  ev_s sbq[$];
  int acc[$];
  int cyc = 0, r = 0, tests = 0, fails = 0, drops = 0, unstable = 0, vhigh = 0;

  key_event_gen #(.NKEYS(4), .KW(2), .TICK_DIV(TD), .NTBITS(16), .DELAY_MS(DL),
                  .REPEAT_MS(RP), .MSBITS(8), .REPEAT_MASK(MASK)) dut (
    .Clk(clk), .Rst_n(rst_n), .KeyClean(keys), .EventValid(valid),
    .EventCode(code), .EventReady(ready), .Drop(drop));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // key k pressed after edge c, released after edge d; ticks fall on edges (e-r)%TD==0
  task automatic model(input int k, input int c, input int d, input bit push, output int nreq);
    int cnt = 0;
    bit first = 1;
    nreq = 1;
    if (push) sbq.push_back('{k, c + 2});
    if (MASK[k])
      for (int e = c + 2; e <= d; e++)
        if ((e - r) % TD == 0) begin
          cnt++;
          if (cnt == (first ? DL : RP)) begin
            nreq++;
            cnt = 0;
            first = 0;
            if (push) sbq.push_back('{k, e + 1});
          end
        end
  endtask

  initial begin
    logic pv, pr;
    logic [1:0] pc;
    ev_s e;
    pv = 0; pr = 0; pc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 0;
      else begin
        if (pv && !pr) unstable += int'(!valid || code != pc);
        if (valid) vhigh++;
        if (valid && ready) begin
          check("ev_expected", int'(sbq.size() > 0), 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("ev_code", code, e.code);
            if (e.t >= 0) check("ev_time", cyc, e.t);
          end
          acc.push_back(cyc);
        end
        if (drop) drops++;
        pv = valid; pr = ready; pc = code;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int c, d, n, d0, a0, v0;
    #3;
    check("rst_valid", valid, 0);
    check("rst_code", code, 0);
    check("rst_drop", drop, 0);
    step(3);
    rst_n = 1;
    r = cyc;
    step(2);
    ready = 0;
    keys = 4'b0001;
    c = cyc;
    for (int i = 0; i < 10 && !valid; i++) @(negedge clk);
    check("t1_valid", valid, 1);
    check("t1_lat", cyc, c + 2);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("t1_rst_valid", valid, 0);
    check("t1_rst_code", code, 0);
    check("t1_rst_drop", drop, 0);
    keys = '0;
    ready = 1;
    step(2);
    rst_n = 1;
    r = cyc;
    a0 = acc.size();
    step(20);
    check("t1_quiet", acc.size() - a0, 0);
    c = cyc;
    keys = 4'b0001;
    model(0, c, c + 3, 1, n);
    step(3);
    keys = '0;
    step(6);
    check("t1_left", sbq.size(), 0);
    a0 = acc.size();
    v0 = vhigh;
    c = cyc;
    keys = 4'b0100;
    model(2, c, c + 3, 1, n);
    step(3);
    keys = '0;
    step(12);
    check("t2_events", acc.size() - a0, 1);
    check("t2_vhigh", vhigh - v0, 1);
    check("t2_left", sbq.size(), 0);
    a0 = acc.size();
    c = cyc;
    keys = 4'b0010;
    model(1, c, c + 60, 1, n);
    step(60);
    keys = '0;
    step(10);
    check("t3_events", acc.size() - a0, n);
    check("t3_left", sbq.size(), 0);
    if (acc.size() - a0 >= 3) begin
      check("t3_gap1", int'(acc[a0+1] - acc[a0] >= 9 && acc[a0+1] - acc[a0] <= 12), 1);
      check("t3_gap2", acc[a0+2] - acc[a0+1], 8);
    end
    a0 = acc.size();
    c = cyc;
    keys = 4'b1000;
    model(3, c, c + 60, 1, n);
    step(60);
    keys = '0;
    step(6);
    check("t4_events", acc.size() - a0, 1);
    check("t4_left", sbq.size(), 0);
    d0 = drops;
    c = cyc;
    keys = 4'b1011;
    sbq.push_back('{0, c + 2});
    sbq.push_back('{1, c + 4});
    sbq.push_back('{3, c + 6});
    step(7);
    keys = '0;
    step(6);
    check("t5_drop", drops - d0, 0);
    check("t5_left", sbq.size(), 0);
    d0 = drops;
    a0 = acc.size();
    unstable = 0;
    ready = 0;
    c = cyc;
    keys = 4'b0001;
    step(40);
    d = cyc;
    model(0, c, d, 0, n);
    check("t6_hold_valid", valid, 1);
    check("t6_hold_code", code, 0);
    sbq.push_back('{0, -1});
    sbq.push_back('{0, -1});
    keys = '0;
    ready = 1;
    step(8);
    check("t6_drops", drops - d0, n - 2);
    check("t6_events", acc.size() - a0, 2);
    check("t6_stable", unstable, 0);
    check("t6_left", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_event_gen.md
# key_event_gen

Turns the debounced, level-type button signals from the `debounce` instances into discrete key events for the game controller. It emits one event on each press, then typematic auto-repeat events while a key is held. Events are queued per key and presented on a valid/ready port as an encoded key index. It sits between the per-button `debounce` stages and the Tetris game FSM.

## Interface
- `NKEYS`, 4: number of key inputs.
- `KW`, 2: width of `EventCode`; must satisfy 2^KW >= NKEYS.
- `TICK_DIV`, 50000: `Clk` cycles per millisecond tick (50 MHz).
- `NTBITS`, 16: prescaler width; must satisfy 2^NTBITS > TICK_DIV-1.
- `DELAY_MS`, 250: ticks from press to the first repeat.
- `REPEAT_MS`, 80: ticks between subsequent repeats.
- `MSBITS`, 8: per-key tick counter width; must hold max(DELAY_MS, REPEAT_MS)-1.
- `REPEAT_MASK`, 4'b0111: bit i=1 enables auto-repeat for key i (rotate on key 3 does not repeat).

Ports:
- `Clk` in 1: system clock.
- `Rst_n` in 1: asynchronous active-low reset.
- `KeyClean` in NKEYS: debounced key levels, synchronous to `Clk`, 1 = pressed.
- `EventValid` out 1: an event is presented.
- `EventCode` out KW: index of the key that produced the event.
- `EventReady` in 1: consumer accepts the event this cycle.
- `Drop` out 1: one-cycle pulse when an event is discarded.

## Operation
- Reset values (async, `Rst_n`=0):
  - `EventValid`=0, `EventCode`=0, `Drop`=0.
  - Prescaler=0, all key-previous registers=0, all pending bits=0.
  - All key states IDLE, all tick counters 0.
- Prescaler: free-running, counts 0..TICK_DIV-1 and then wraps to 0. `tick`=1 for the single cycle when the count equals TICK_DIV-1.
- Per-key FSM (independent per key i), states IDLE, DELAY, REPEAT, HELD:
  - IDLE: a rising edge (`KeyClean[i]`=1, prev=0) raises a request, clears the counter and moves to DELAY if `REPEAT_MASK[i]` is set, else to HELD.
  - DELAY: on `tick`:
    - if counter == DELAY_MS-1, raise a request, clear the counter and go to REPEAT;
    - else increment the counter.
  - REPEAT: the same as DELAY, using REPEAT_MS-1. It stays in REPEAT after each request.
  - HELD: no further requests.
  - In any state, `KeyClean[i]`=0 forces IDLE and clears the counter that cycle; no request is raised.
- Pending bits:
  - A request sets `pend[i]`.
  - If `pend[i]` is already 1 and is not being transferred to the output this cycle, the request is discarded and `Drop` pulses.
- Output slot: when `EventValid`=0 and any pend bit is set, the lowest-index pending key is loaded:
  - `EventValid` is set to 1, `EventCode` is set to i, and `pend[i]` is cleared.
  - A request on the same key in the same cycle leaves `pend[i]`=1 and is not a drop.
- Handshake:
  - `EventValid` and `EventCode` are held stable until the cycle with `EventReady`=1, then `EventValid` returns to 0.
  - The slot reloads only when `EventValid`=0, so there is one idle cycle between events.
  - `EventReady` is ignored while `EventValid`=0.

## Timing
- Press latency: `KeyClean[i]` high at edge E0 (prev low) sets `pend[i]` at E0. `EventValid` is high after E1 if the slot was free.
- First repeat arrives DELAY_MS ticks after the press edge. Jitter is up to TICK_DIV-1 cycles because the first tick is partial.
- Repeat period is exactly REPEAT_MS*TICK_DIV cycles.
- Maximum throughput is one event per 2 cycles.
- Simultaneous presses are serviced in lowest-index-first order. Lower indices can starve higher ones only under continuous repeat, which is acceptable at ms rates.
- Release and re-press is a fresh press: an immediate event, and the DELAY restarts.

## Test plan
Simulation parameters: TICK_DIV=4, DELAY_MS=3, REPEAT_MS=2, `EventReady`=1 unless stated.
1. Reset mid-operation: hold key 0, then assert `Rst_n`=0 while `EventValid`=1. Required: all outputs drop to 0 immediately. After release, no event appears until a new rising edge.
2. Single tap on key 2 for 3 cycles. Required: exactly one event with `EventCode`=2, `EventValid` high for 1 cycle, 2 edges after the rise; no repeats.
3. Hold key 1 for 60 cycles. Required:
   - press event;
   - first repeat 9–12 cycles later;
   - further repeats every 8 cycles;
   - none after release.
4. Hold key 3 (mask 0) for 60 cycles. Required: exactly one event.
5. Keys 0, 1 and 3 rise in the same cycle. Required: events with codes 0, 1, 3 in that order, spaced 2 cycles apart; `Drop` stays 0.
6. Backpressure: `EventReady`=0 while key 0 is held for 40 cycles. Required:
   - the first event is held stable;
   - one pending event is queued;
   - each further repeat pulses `Drop`;
   - after `EventReady`=1, exactly 2 code-0 events are delivered.
